// File: rtl/rob_pkg.sv
// Shared ROB constants and the per-entry record seen by the retire selector.
package rob_pkg;

    localparam int ROB_DEPTH = 16;
    localparam int ROB_PTR_W = $clog2(ROB_DEPTH);
    localparam int RRF_TAG_W = 7;
    localparam int ARCH_W    = 3;

    typedef struct packed {
        logic                 valid;
        logic                 done;
        logic                 has_dest;
        logic [ARCH_W-1:0]    arch_idx;
        logic [RRF_TAG_W-1:0] rrf_tag;
        logic                 is_branch;
        logic                 mispred;
    } rob_entry_t;

endpackage

// File: rtl/rob_retire_sel.sv
// Combinational in-order retire selection for the two oldest ROB entries.
module rob_retire_sel
    import rob_pkg::*;
(
    input  rob_entry_t            head_ent,
    input  rob_entry_t            next_ent,
    output logic                  write_valid1,
    output logic                  write_valid2,
    output logic [ARCH_W-1:0]     write_index1,
    output logic [ARCH_W-1:0]     write_index2,
    output logic [RRF_TAG_W-1:0]  rrf_read_idx1,
    output logic [RRF_TAG_W-1:0]  rrf_read_idx2,
    output logic [1:0]            retire_cnt,
    output logic                  flush_out
);

    logic r0;
    logic r1;
    logic unused_bits;

    // A mispredicted head retires alone so nothing on the wrong path commits.
    assign r0 = head_ent.valid && head_ent.done;
    assign r1 = r0 && !head_ent.mispred && next_ent.valid && next_ent.done;

    assign write_valid1  = r0 && head_ent.has_dest;
    assign write_valid2  = r1 && next_ent.has_dest;
    assign write_index1  = write_valid1 ? head_ent.arch_idx : '0;
    assign write_index2  = write_valid2 ? next_ent.arch_idx : '0;
    assign rrf_read_idx1 = write_valid1 ? head_ent.rrf_tag  : '0;
    assign rrf_read_idx2 = write_valid2 ? next_ent.rrf_tag  : '0;

    assign retire_cnt = {r1, r0 && !r1};
    assign flush_out  = r0 && head_ent.mispred;

    assign unused_bits = ^{head_ent.is_branch, next_ent.is_branch, next_ent.mispred};

endmodule

// File: rtl/rob.sv
// Reorder buffer: 2-wide in-order dispatch, 3-port completion, 2-wide in-order retire.
module rob #(
    parameter int DEPTH  = rob_pkg::ROB_DEPTH,
    parameter int PTR_W  = rob_pkg::ROB_PTR_W,
    parameter int TAG_W  = rob_pkg::RRF_TAG_W,
    parameter int ARCH_W = rob_pkg::ARCH_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush_in,
    input  logic              disp_valid1,
    input  logic              disp_valid2,
    input  logic              disp_has_dest1,
    input  logic              disp_has_dest2,
    input  logic [ARCH_W-1:0] disp_arch_idx1,
    input  logic [ARCH_W-1:0] disp_arch_idx2,
    input  logic [TAG_W-1:0]  disp_rrf_tag1,
    input  logic [TAG_W-1:0]  disp_rrf_tag2,
    input  logic              disp_is_branch1,
    input  logic              disp_is_branch2,
    output logic              two_free,
    output logic [PTR_W-1:0]  disp_rob_idx1,
    output logic [PTR_W-1:0]  disp_rob_idx2,
    input  logic              cmpl_en1,
    input  logic              cmpl_en2,
    input  logic              cmpl_en3,
    input  logic [PTR_W-1:0]  cmpl_idx1,
    input  logic [PTR_W-1:0]  cmpl_idx2,
    input  logic [PTR_W-1:0]  cmpl_idx3,
    input  logic              cmpl_mispred1,
    input  logic              cmpl_mispred2,
    input  logic              cmpl_mispred3,
    output logic              rob_write_valid1,
    output logic              rob_write_valid2,
    output logic [ARCH_W-1:0] rob_write_index1,
    output logic [ARCH_W-1:0] rob_write_index2,
    output logic [TAG_W-1:0]  rob_rrf_read_idx1,
    output logic [TAG_W-1:0]  rob_rrf_read_idx2,
    output logic [1:0]        retire_cnt,
    output logic              flush_out
);
    import rob_pkg::*;

    localparam int CNT_W = PTR_W + 1;

    logic [PTR_W-1:0]  head;
    logic [PTR_W-1:0]  tail;
    logic [PTR_W-1:0]  head1;
    logic [PTR_W-1:0]  tail1;
    logic [CNT_W-1:0]  count;

    logic [DEPTH-1:0]  valid;
    logic [DEPTH-1:0]  done;
    logic [DEPTH-1:0]  mispred;
    logic [DEPTH-1:0]  valid_nxt;
    logic [DEPTH-1:0]  done_nxt;
    logic [DEPTH-1:0]  mispred_nxt;

    logic [DEPTH-1:0]  has_dest;
    logic [DEPTH-1:0]  is_branch;
    logic [ARCH_W-1:0] arch_idx [DEPTH];
    logic [TAG_W-1:0]  rrf_tag  [DEPTH];

    logic              do_disp;
    logic              do_disp2;
    logic [1:0]        n_disp;
    logic              clear;
    logic              ret1;
    logic              ret2;
    rob_entry_t        head_ent;
    rob_entry_t        next_ent;

    assign head1 = head + PTR_W'(1);
    assign tail1 = tail + PTR_W'(1);

    // Free space comes from the registered count only; same-cycle retires do not help.
    assign two_free      = (count <= CNT_W'(DEPTH - 2));
    assign disp_rob_idx1 = tail;
    assign disp_rob_idx2 = tail1;

    assign clear    = flush_in || flush_out;
    assign do_disp  = disp_valid1 && two_free && !clear;
    assign do_disp2 = do_disp && disp_valid2;
    assign n_disp   = do_disp2 ? 2'd2 : (do_disp ? 2'd1 : 2'd0);

    assign ret1 = (retire_cnt != 2'd0);
    assign ret2 = retire_cnt[1];

    always_comb begin
        head_ent.valid     = valid[head];
        head_ent.done      = done[head];
        head_ent.has_dest  = has_dest[head];
        head_ent.arch_idx  = arch_idx[head];
        head_ent.rrf_tag   = rrf_tag[head];
        head_ent.is_branch = is_branch[head];
        head_ent.mispred   = mispred[head];
        next_ent.valid     = valid[head1];
        next_ent.done      = done[head1];
        next_ent.has_dest  = has_dest[head1];
        next_ent.arch_idx  = arch_idx[head1];
        next_ent.rrf_tag   = rrf_tag[head1];
        next_ent.is_branch = is_branch[head1];
        next_ent.mispred   = mispred[head1];
    end

    rob_retire_sel u_retire_sel (
        .head_ent      (head_ent),
        .next_ent      (next_ent),
        .write_valid1  (rob_write_valid1),
        .write_valid2  (rob_write_valid2),
        .write_index1  (rob_write_index1),
        .write_index2  (rob_write_index2),
        .rrf_read_idx1 (rob_rrf_read_idx1),
        .rrf_read_idx2 (rob_rrf_read_idx2),
        .retire_cnt    (retire_cnt),
        .flush_out     (flush_out)
    );

    // Entry status: completion, then retire clear, then dispatch; a flush overrides all.
    always_comb begin
        valid_nxt   = valid;
        done_nxt    = done;
        mispred_nxt = mispred;

        if (cmpl_en1 && valid[cmpl_idx1]) begin
            done_nxt[cmpl_idx1]    = 1'b1;
            mispred_nxt[cmpl_idx1] = mispred_nxt[cmpl_idx1] | cmpl_mispred1;
        end
        if (cmpl_en2 && valid[cmpl_idx2]) begin
            done_nxt[cmpl_idx2]    = 1'b1;
            mispred_nxt[cmpl_idx2] = mispred_nxt[cmpl_idx2] | cmpl_mispred2;
        end
        if (cmpl_en3 && valid[cmpl_idx3]) begin
            done_nxt[cmpl_idx3]    = 1'b1;
            mispred_nxt[cmpl_idx3] = mispred_nxt[cmpl_idx3] | cmpl_mispred3;
        end

        if (ret1) begin
            valid_nxt[head]   = 1'b0;
            done_nxt[head]    = 1'b0;
            mispred_nxt[head] = 1'b0;
        end
        if (ret2) begin
            valid_nxt[head1]   = 1'b0;
            done_nxt[head1]    = 1'b0;
            mispred_nxt[head1] = 1'b0;
        end

        if (do_disp) begin
            valid_nxt[tail]   = 1'b1;
            done_nxt[tail]    = 1'b0;
            mispred_nxt[tail] = 1'b0;
        end
        if (do_disp2) begin
            valid_nxt[tail1]   = 1'b1;
            done_nxt[tail1]    = 1'b0;
            mispred_nxt[tail1] = 1'b0;
        end

        if (clear) begin
            valid_nxt   = '0;
            done_nxt    = '0;
            mispred_nxt = '0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid   <= '0;
            done    <= '0;
            mispred <= '0;
            head    <= '0;
            tail    <= '0;
            count   <= '0;
        end else begin
            valid   <= valid_nxt;
            done    <= done_nxt;
            mispred <= mispred_nxt;
            if (clear) begin
                head  <= '0;
                tail  <= '0;
                count <= '0;
            end else begin
                head  <= head + PTR_W'(retire_cnt);
                tail  <= tail + PTR_W'(n_disp);
                count <= count + CNT_W'(n_disp) - CNT_W'(retire_cnt);
            end
        end
    end

    // Payload fields are only meaningful while valid is set, so they carry no reset.
    always_ff @(posedge clk) begin
        if (do_disp) begin
            has_dest[tail]  <= disp_has_dest1;
            is_branch[tail] <= disp_is_branch1;
            arch_idx[tail]  <= disp_arch_idx1;
            rrf_tag[tail]   <= disp_rrf_tag1;
        end
        if (do_disp2) begin
            has_dest[tail1]  <= disp_has_dest2;
            is_branch[tail1] <= disp_is_branch2;
            arch_idx[tail1]  <= disp_arch_idx2;
            rrf_tag[tail1]   <= disp_rrf_tag2;
        end
    end

endmodule
